// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, state/ALU/mux encodings and decode helpers; MULDIV_EN makes MULT/DIV legal
package multicycle_control_pkg;
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MULT = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd7;
  localparam logic [4:0] OP_LR   = 5'd8;
  localparam logic [4:0] OP_SR   = 5'd9;
  localparam logic [4:0] OP_BLEQ = 5'd13;
  localparam logic [4:0] OP_AND  = 5'd14;
  localparam logic [4:0] OP_BEQ  = 5'd18;
  localparam logic [4:0] OP_BNEQ = 5'd19;
  localparam logic [4:0] OP_BGEQ = 5'd22;
  localparam logic [4:0] OP_BGT  = 5'd23;
  localparam logic [4:0] OP_MOV  = 5'd27;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM       = 3'd3,
    S_WB        = 3'd4,
    S_HALT      = 3'd5,
    S_EXEC_WAIT = 3'd6
  } state_t;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_MUL  = 4'd4;
  localparam logic [3:0] ALU_DIV  = 4'd5;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BR  = 1'b1;
  localparam logic WB_ALU     = 1'b0;
  localparam logic WB_MEM     = 1'b1;
  localparam logic ADDR_PC    = 1'b0;
  localparam logic ADDR_ALU   = 1'b1;

  function automatic logic is_branch(input logic [4:0] op);
    return op inside {OP_BLEQ, OP_BEQ, OP_BNEQ, OP_BGEQ, OP_BGT};
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return op inside {OP_LR, OP_SR};
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return op inside {OP_MULT, OP_DIV};
  endfunction

  function automatic logic uses_imm(input logic [4:0] op);
    return op inside {OP_ADDI, OP_LR, OP_SR};
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic ok;
    ok = is_branch(op) || is_mem(op) || (op inside {OP_NOP, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_MOV});
`ifdef MULDIV_EN
    ok = ok || is_muldiv(op);
`endif
    return ok;
  endfunction

  function automatic logic [3:0] alu_sel(input logic [4:0] op);
    return (op inside {OP_ADD, OP_ADDI, OP_LR, OP_SR}) ? ALU_ADD :
           (op == OP_SUB || is_branch(op))             ? ALU_SUB :
           (op == OP_AND)                              ? ALU_AND :
           (op == OP_MULT)                             ? ALU_MUL :
           (op == OP_DIV)                              ? ALU_DIV : ALU_PASS;
  endfunction
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: decoder/datapath handshake and control bundle for the sequencing FSM
interface multicycle_control_if #(
  parameter int WIDTH_OPCODE = 5,
  parameter int ALU_OP_BITS  = 4
);
  logic [WIDTH_OPCODE-1:0] opcode;
  logic                    mem_ready;
  logic                    cmp_eq;
  logic                    cmp_lt;
  logic                    alu_done;
  logic                    ir_write;
  logic                    pc_write;
  logic                    pc_src;
  logic                    mem_req;
  logic                    mem_we;
  logic                    mem_addr_sel;
  logic                    alu_src_b;
  logic [ALU_OP_BITS-1:0]  alu_op;
  logic                    alu_start;
  logic                    reg_write;
  logic                    wb_sel;
  logic                    retire;
  logic                    illegal;
  logic [2:0]              state_dbg;

  modport master (
    input  opcode, mem_ready, cmp_eq, cmp_lt, alu_done,
    output ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_src_b,
           alu_op, alu_start, reg_write, wb_sel, retire, illegal, state_dbg
  );

  modport slave (
    output opcode, mem_ready, cmp_eq, cmp_lt, alu_done,
    input  ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_sel, alu_src_b,
           alu_op, alu_start, reg_write, wb_sel, retire, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_branch_cond.sv
// multicycle_control_branch_cond: branch-taken decision from opcode and ALU compare flags
module multicycle_control_branch_cond
  import multicycle_control_pkg::*;
#(
  parameter int WIDTH_OPCODE = 5
) (
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    cmp_eq,
  input  logic                    cmp_lt,
  output logic                    taken
);
  assign taken = (opcode == OP_BEQ  &&  cmp_eq) ||
                 (opcode == OP_BNEQ && !cmp_eq) ||
                 (opcode == OP_BLEQ && (cmp_lt || cmp_eq)) ||
                 (opcode == OP_BGEQ && !cmp_lt) ||
                 (opcode == OP_BGT  && !cmp_lt && !cmp_eq);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/mem/writeback sequencer; MULDIV_EN adds the mult/div wait state
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WIDTH_OPCODE = 5,
  parameter int ALU_OP_BITS  = 4
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);
  state_t                  state, next;
  logic                    taken;
  logic [WIDTH_OPCODE-1:0] op;

  assign op = bus.opcode;

  multicycle_control_branch_cond #(.WIDTH_OPCODE(WIDTH_OPCODE)) u_branch_cond (
    .opcode (op),
    .cmp_eq (bus.cmp_eq),
    .cmp_lt (bus.cmp_lt),
    .taken  (taken)
  );

`ifndef MULDIV_EN
  logic unused_alu_done;
  assign unused_alu_done = bus.alu_done;
`endif

  // state register; reset returns to FETCH from anywhere, including HALT
  always_ff @(posedge clk)
    state <= reset ? S_FETCH : next;

  // next-state: memory states hold for mem_ready, HALT holds until reset
  always_comb begin
    next = state;
    case (state)
      S_FETCH:  next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next = (op == OP_NOP) ? S_FETCH : is_legal(op) ? S_EXEC : S_HALT;
      S_EXEC:   next = is_branch(op) ? S_FETCH : is_mem(op) ? S_MEM : is_muldiv(op) ? S_EXEC_WAIT : S_WB;
      S_MEM:    next = !bus.mem_ready ? S_MEM : (op == OP_LR) ? S_WB : S_FETCH;
      S_WB:     next = S_FETCH;
      S_HALT:   next = S_HALT;
`ifdef MULDIV_EN
      S_EXEC_WAIT: next = bus.alu_done ? S_WB : S_EXEC_WAIT;
`endif
      default:  next = S_FETCH;
    endcase
  end

  // control outputs from state qualified by opcode; all forced low while reset is high
  always_comb begin
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_SRC_SEQ;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = ADDR_PC;
    bus.alu_src_b    = 1'b0;
    bus.alu_op       = ALU_OP_BITS'(ALU_PASS);
    bus.alu_start    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.retire       = 1'b0;
    bus.illegal      = 1'b0;
    bus.state_dbg    = reset ? 3'd0 : state;
    if (!reset)
      case (state)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_DECODE: bus.retire = (op == OP_NOP);
        S_EXEC: begin
          bus.alu_op    = ALU_OP_BITS'(alu_sel(op));
          bus.alu_src_b = uses_imm(op);
          bus.pc_write  = taken;
          bus.pc_src    = taken ? PC_SRC_BR : PC_SRC_SEQ;
          bus.retire    = is_branch(op);
`ifdef MULDIV_EN
          bus.alu_start = is_muldiv(op);
`endif
        end
        S_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = ADDR_ALU;
          bus.mem_we       = (op == OP_SR);
          bus.retire       = bus.mem_ready && (op == OP_SR);
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = (op == OP_LR) ? WB_MEM : WB_ALU;
          bus.retire    = 1'b1;
        end
        S_EXEC_WAIT: bus.alu_op = ALU_OP_BITS'(alu_sel(op));
        S_HALT:      bus.illegal = 1'b1;
        default: ;
      endcase
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main sequencing FSM for the multicycle 19-bit processor.
- Takes the 5-bit opcode from the instruction register and walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Drives PC, IR, register-file, ALU and memory control, with a variable-latency memory handshake.
- Sits between the instruction decoder and the datapath muxes; one instance per core.

Parameters:
- WIDTH_OPCODE, 5, opcode field width.
- ALU_OP_BITS, 4, width of the ALU function select.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  WIDTH_OPCODE  opcode from the instruction register, stable from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- cmp_eq  in  1  ALU result (reg_source - reg_n) is zero.
- cmp_lt  in  1  ALU signed result is negative.
- alu_done  in  1  multi-cycle ALU finished (used only with MULDIV_EN).
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+1, 1 = PC+1+sign-extended immediate.
- mem_req  out  1  memory request.
- mem_we  out  1  request is a write.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- alu_src_b  out  1  0 = reg_n, 1 = immediate.
- alu_op  out  ALU_OP_BITS  0 pass-A, 1 add, 2 sub, 3 and, 4 mult, 5 div.
- alu_start  out  1  one-cycle start pulse for mult/div.
- reg_write  out  1  write reg_dest.
- wb_sel  out  1  0 = ALU result, 1 = memory data.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  sticky; an unknown opcode was decoded.
- state_dbg  out  3  current state encoding.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous, active-high. While reset is high, every output is 0 and the state loads FETCH. This also applies mid-instruction: mem_req drops on the cycle after reset is sampled.
- Opcodes: NOP=0, ADD=1, ADDI=2, SUB=3, MULT=5, DIV=7, LR=8, SR=9, BLEQ=13, AND=14, BEQ=18, BNEQ=19, BGEQ=22, BGT=23, MOV=27. Any other value is illegal.
- Output style: outputs are combinational from the registered state and opcode (Moore on state, qualified by opcode). State is one-hot or binary; state_dbg reports the binary encoding below.
- FETCH(0):
  - mem_req=1, mem_addr_sel=0; hold until mem_ready.
  - On the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE(1), one cycle:
  - NOP: retire=1, go to FETCH.
  - Illegal opcode: go to HALT.
  - Otherwise: go to EXECUTE.
- EXECUTE(2):
  - ADD/SUB/AND: alu_src_b=0, then WRITEBACK.
  - ADDI: alu_op=add, alu_src_b=1, then WRITEBACK.
  - MOV: alu_op=pass-A, then WRITEBACK.
  - LR/SR: alu_op=add, alu_src_b=1, then MEM.
  - Branches: alu_op=sub, alu_src_b=0. Taken conditions are BEQ eq; BNEQ !eq; BLEQ lt|eq; BGEQ !lt; BGT !lt&!eq. If taken, pc_write=1 and pc_src=1. retire=1, then FETCH.
- MEM(3):
  - mem_req=1, mem_addr_sel=1, mem_we=(SR); hold until mem_ready.
  - On ready: LR goes to WRITEBACK; SR asserts retire and goes to FETCH.
- WRITEBACK(4): reg_write=1, wb_sel=(LR), retire=1, then FETCH.
- HALT(5): all outputs 0 except illegal=1. Only reset exits. illegal clears only on reset.
- Cycle counts with zero-wait memory:
  - NOP 2.
  - Branch 3, taken or not.
  - ADD/ADDI/SUB/AND/MOV/SR 4.
  - LR 5.
  - Each memory wait cycle adds 1.
- Boundary conditions:
  - mem_ready outside FETCH/MEM is ignored.
  - mem_req stays asserted with constant address select until mem_ready.
  - Writes to R0 are not blocked here; the register file handles R0.

Optional Feature:
- Macro: MULDIV_EN.
- Defined:
  - MULT/DIV pass DECODE and enter EXECUTE, which pulses alu_start=1 with alu_op 4/5 for exactly one cycle, then enters EXEC_WAIT(6).
  - EXEC_WAIT holds alu_op until alu_done, then goes to WRITEBACK.
  - If alu_done arrives on the same cycle as the start pulse, it is ignored.
- Undefined: opcodes 5 and 7 are illegal (go to HALT). alu_start is tied 0 and alu_done is unused.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams;
  - state encodings;
  - alu_op codes;
  - pc_src, wb_sel and mem_addr_sel encodings.
- One sub-module, branch_cond: combinational; opcode, cmp_eq and cmp_lt in, taken out. Unit-tested separately.

Test Plan:
- Reset, then ADD opcode=1, mem_ready always 1:
  - ir_write at cycle 0, reg_write at cycle 3, retire at cycle 3;
  - state sequence 0,1,2,4,0.
- LR opcode=8 with mem_ready delayed 2 cycles in both FETCH and MEM:
  - retire at cycle 8;
  - mem_we=0 and mem_addr_sel=1 throughout MEM.
- BLEQ opcode=13:
  - cmp_lt=1: pc_write=1 and pc_src=1 in EXECUTE.
  - cmp_eq=0, cmp_lt=0: pc_write=0.
  - Both cases return to FETCH after 3 cycles.
- Opcode=4 (undefined):
  - HALT after DECODE, illegal=1, stays for 10 cycles with mem_req=0;
  - reset clears it to FETCH.
- reset asserted during the MEM wait of SR:
  - next cycle mem_req=0 and state=FETCH;
  - no retire pulse.
- MULDIV_EN, opcode=5, alu_done after 4 cycles:
  - single alu_start pulse;
  - reg_write one cycle after alu_done.
  - Without MULDIV_EN, the same stimulus goes to HALT.
